morse_key_conditioner: RTL and testbench



---
 rtl/morse_key_conditioner_if.sv | 21 ++
 rtl/morse_key_conditioner.sv | 101 ++++++++++
 tb/tb_morse_key_conditioner.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/morse_key_conditioner_if.sv
// Key-conditioner signal bundle: raw key pin in, debounced level, strobes and press length out.
interface morse_key_conditioner_if #(
  parameter int LEN_W = 16
);
  logic             button_raw;
  logic             button_clean;
  logic             press_pulse;
  logic             release_pulse;
  logic [LEN_W-1:0] press_len;
  logic             press_len_valid;

  modport master (
    output button_raw,
    input  button_clean, press_pulse, release_pulse, press_len, press_len_valid
  );

  modport slave (
    input  button_raw,
    output button_clean, press_pulse, release_pulse, press_len, press_len_valid
  );
endinterface

// File: rtl/morse_key_conditioner.sv
// Synchronises and debounces a raw Morse key, emitting a clean level, press/release
// strobes and the measured press duration for the downstream decoder.
module morse_key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LEN_W           = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  morse_key_conditioner_if.slave  kif
);
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("DEBOUNCE_CYCLES must be >= 1");
  end

  // Bit 1 of the encoding is the debounced level, so button_clean decodes glitch-free.
  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_PEND   = 2'b01,
    HELD         = 2'b10,
    RELEASE_PEND = 2'b11
  } state_e;

  state_e           state, state_nxt;
  logic [1:0]       sync_pipe;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic [LEN_W-1:0] len_cnt, len_inc, press_len_q;
  logic             press_q, release_q;
  logic             clean, differ, commit, rise, fall;

  assign s2 = sync_pipe[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[0], kif.button_raw};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; commit takes priority so DEBOUNCE_CYCLES=1 skips the pending state.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:         if (commit) state_nxt = HELD;
                    else if (s2) state_nxt = PRESS_PEND;
      PRESS_PEND:   if (commit) state_nxt = HELD;
                    else if (!s2) state_nxt = IDLE;
      HELD:         if (commit) state_nxt = IDLE;
                    else if (!s2) state_nxt = RELEASE_PEND;
      RELEASE_PEND: if (commit) state_nxt = IDLE;
                    else if (s2) state_nxt = HELD;
      default:      state_nxt = IDLE;
    endcase
  end

  // Output / qualifier decode
  always_comb begin
    clean   = state[1];
    differ  = (s2 != clean);
    commit  = differ && (cnt == CNT_LAST);
    rise    = commit && !clean;
    fall    = commit && clean;
    len_inc = (&len_cnt) ? len_cnt : len_cnt + 1'b1;
  end

  // Any cycle at the settled level drops a partial count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (differ && !commit) cnt <= cnt + 1'b1;
    else                       cnt <= '0;
  end

  // Counts every edge with clean=1, so the falling-commit edge is included via len_inc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_cnt     <= '0;
      press_len_q <= '0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
    end else begin
      press_q   <= rise;
      release_q <= fall;
      if (rise)       len_cnt <= '0;
      else if (clean) len_cnt <= len_inc;
      if (fall)       press_len_q <= len_inc;
    end
  end

  assign kif.button_clean    = clean;
  assign kif.press_pulse     = press_q;
  assign kif.release_pulse   = release_q;
  assign kif.press_len_valid = release_q;
  assign kif.press_len       = press_len_q;
endmodule

// File: tb/tb_morse_key_conditioner.sv
// Scoreboard bench: stimulus pushes expected strobe cycles/lengths, negedge monitors pop and compare
// for a 16-bit and a 4-bit (saturating) instance sharing the same key input.
module tb_morse_key_conditioner;
  localparam int DC = 4;

  typedef struct { int cyc; int len; } rel_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic raw = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int   pq16[$], pq4[$];
  rel_t rq16[$], rq4[$];

  morse_key_conditioner_if #(.LEN_W(16)) kif16();
  morse_key_conditioner_if #(.LEN_W(4))  kif4();

  assign kif16.button_raw = raw;
  assign kif4.button_raw  = raw;

  morse_key_conditioner #(.DEBOUNCE_CYCLES(DC), .LEN_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .kif(kif16));
  morse_key_conditioner #(.DEBOUNCE_CYCLES(DC), .LEN_W(4))  dut4  (.clk(clk), .rst_n(rst_n), .kif(kif4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_press(input int c);
    pq16.push_back(c);
    pq4.push_back(c);
  endtask

  task automatic push_rel(input int c, input int len);
    rel_t r16, r4;
    r16.cyc = c; r16.len = len;
    r4.cyc  = c; r4.len  = (len > 15) ? 15 : len;
    rq16.push_back(r16);
    rq4.push_back(r4);
  endtask

  // Clean raw pulse of w cycles followed by gap low cycles; call just after a negedge.
  task automatic press(input int w, input int gap);
    int c;
    c = cyc;
    raw = 1'b1;
    push_press(c + DC + 2);
    push_rel(c + w + DC + 2, w);
    repeat (w) @(negedge clk);
    raw = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_clean16"}, kif16.button_clean, 0);
    chk({tag, "_press16"}, kif16.press_pulse, 0);
    chk({tag, "_rel16"},   kif16.release_pulse, 0);
    chk({tag, "_vld16"},   kif16.press_len_valid, 0);
    chk({tag, "_len16"},   int'(kif16.press_len), 0);
    chk({tag, "_clean4"},  kif4.button_clean, 0);
    chk({tag, "_rel4"},    kif4.release_pulse, 0);
    chk({tag, "_len4"},    int'(kif4.press_len), 0);
  endtask

  always @(negedge clk) if (rst_n) begin
    if (kif16.press_pulse) begin
      if (pq16.size() == 0) chk("press16_unexpected", cyc, -1);
      else begin
        chk("press16_cyc", cyc, pq16.pop_front());
        chk("press16_clean", kif16.button_clean, 1);
      end
    end
    if (kif16.release_pulse || kif16.press_len_valid) begin
      chk("rel16_vld_coincide", kif16.release_pulse, kif16.press_len_valid);
      if (rq16.size() == 0) chk("rel16_unexpected", cyc, -1);
      else begin
        rel_t r;
        r = rq16.pop_front();
        chk("rel16_cyc", cyc, r.cyc);
        chk("rel16_len", int'(kif16.press_len), r.len);
        chk("rel16_clean", kif16.button_clean, 0);
      end
    end
  end

  always @(negedge clk) if (rst_n) begin
    if (kif4.press_pulse) begin
      if (pq4.size() == 0) chk("press4_unexpected", cyc, -1);
      else chk("press4_cyc", cyc, pq4.pop_front());
    end
    if (kif4.release_pulse || kif4.press_len_valid) begin
      chk("rel4_vld_coincide", kif4.release_pulse, kif4.press_len_valid);
      if (rq4.size() == 0) chk("rel4_unexpected", cyc, -1);
      else begin
        rel_t r;
        r = rq4.pop_front();
        chk("rel4_cyc", cyc, r.cyc);
        chk("rel4_len", int'(kif4.press_len), r.len);
      end
    end
  end

  initial begin
    int c, r, d;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Short 3-cycle blip: rejected, nothing queued so any strobe is flagged.
    raw = 1'b1;
    repeat (3) @(negedge clk);
    raw = 1'b0;
    repeat (10) @(negedge clk);
    chk("short_len16", int'(kif16.press_len), 0);
    chk("short_clean16", kif16.button_clean, 0);

    press(10, 12);
    chk("after10_len16", int'(kif16.press_len), 10);

    // 20-cycle hold with a 2-cycle dip at cycle 8.
    c = cyc;
    raw = 1'b1;
    push_press(c + DC + 2);
    push_rel(c + 20 + DC + 2, 20);
    repeat (8) @(negedge clk);
    raw = 1'b0;
    repeat (2) @(negedge clk);
    raw = 1'b1;
    chk("glitch_clean16", kif16.button_clean, 1);
    repeat (10) @(negedge clk);
    raw = 1'b0;
    repeat (12) @(negedge clk);

    // Long press: 4-bit instance saturates at 15.
    press(40, 12);
    chk("sat_len4", int'(kif4.press_len), 15);
    chk("sat_len16", int'(kif16.press_len), 40);

    // Reset mid-press, key still down afterwards.
    c = cyc;
    raw = 1'b1;
    push_press(c + DC + 2);
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    d = c + 30;
    push_press(r + DC + 2);
    push_rel(d + DC + 2, d - r);
    repeat (d - cyc) @(negedge clk);
    raw = 1'b0;
    repeat (12) @(negedge clk);

    press(12, 10);
    chk("hold12_len16", int'(kif16.press_len), 12);
    chk("hold12_len4", int'(kif4.press_len), 12);
    press(5, 12);
    chk("final_len16", int'(kif16.press_len), 5);

    repeat (5) @(negedge clk);
    chk("pq16_left", pq16.size(), 0);
    chk("pq4_left", pq4.size(), 0);
    chk("rq16_left", rq16.size(), 0);
    chk("rq4_left", rq4.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
